ternary_weight_loader: RTL

Streaming writer for the ternary synapse array. It accepts signed 2-bit ternary weights (−1, 0, +1) over a valid/ready handshake and encodes each into the `weight_zero`/`weight_sign` pair that synapse multipliers consume. Weights collect in a shadow bank. A single commit pulse transfers the bank atomically to the active outputs, so the synapse array never sees a half-loaded weight set. The block sits between the chip pin interface and the synapse array.

---
 rtl/ternary_weight_loader_if.sv | 65 ++++++
 rtl/ternary_weight_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ternary_weight_loader_if.sv
// ----------------------------------------------------------------------------
// ternary_weight_loader_if
//
// Purpose: groups the weight-stream handshake, the commit control and the
// active weight outputs of ternary_weight_loader into a single bundle.
//
// Signals:
//   load_start    : abort and restart the current fill
//   w_valid       : w_val holds a weight
//   w_val         : signed ternary code (01 = +1, 00 = 0, 11 = -1, 10 illegal)
//   w_ready       : loader can accept a weight
//   commit        : copy the shadow bank to the active outputs
//   weight_zero   : active zero flags, 1 = weight is 0
//   weight_sign   : active sign flags, 1 = weight is negative
//   weights_valid : at least one commit has happened since reset
//   count         : number of shadow slots filled
//   err           : sticky illegal-code flag
//
// Modports:
//   master : the weight source (pin interface side)
//   slave  : the loader itself
// ----------------------------------------------------------------------------
interface ternary_weight_loader_if #(
    parameter int N_SYNAPSES = 8,
    parameter int CNT_W      = $clog2(N_SYNAPSES + 1)
) ();

    logic                    load_start;
    logic                    w_valid;
    logic signed [1:0]       w_val;
    logic                    w_ready;
    logic                    commit;
    logic [N_SYNAPSES-1:0]   weight_zero;
    logic [N_SYNAPSES-1:0]   weight_sign;
    logic                    weights_valid;
    logic [CNT_W-1:0]        count;
    logic                    err;

    modport master (
        output load_start,
        output w_valid,
        output w_val,
        output commit,
        input  w_ready,
        input  weight_zero,
        input  weight_sign,
        input  weights_valid,
        input  count,
        input  err
    );

    modport slave (
        input  load_start,
        input  w_valid,
        input  w_val,
        input  commit,
        output w_ready,
        output weight_zero,
        output weight_sign,
        output weights_valid,
        output count,
        output err
    );

endinterface

// File: rtl/ternary_weight_loader.sv
// ----------------------------------------------------------------------------
// ternary_weight_loader
//
// Purpose: streaming writer for the ternary synapse array. Signed 2-bit
// ternary weights arrive over a valid/ready handshake, are encoded into the
// zero/sign pair the synapse multipliers use, and collect in a shadow bank.
// A commit in the FULL state copies the whole bank to the active outputs in
// one edge, so the array never sees a partly loaded weight set.
//
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ternary_weight_loader_if.slave (handshake, commit, active weights,
//          fill count, error flag)
//
// Parameters:
//   N_SYNAPSES : number of weight slots (2..64)
//   CNT_W      : width of count
//
// Configuration macro:
//   TERNARY_ILLEGAL_CHECK_EN : when defined, an accepted code 2'b10 sets the
//   sticky err flag and is stored as weight 0. When undefined, err is tied to
//   0 and 2'b10 is encoded by the plain rule (treated as -1).
// ----------------------------------------------------------------------------
module ternary_weight_loader #(
    parameter int N_SYNAPSES = 8,
    parameter int CNT_W      = $clog2(N_SYNAPSES + 1)
) (
    input logic                     clk,
    input logic                     rst,
    ternary_weight_loader_if.slave  bus
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    logic                    w_ready_int;
    logic                    restart;
    logic                    do_commit;
    logic                    accept;
    logic                    last_slot;

    logic [CNT_W-1:0]        count_q;
    logic [N_SYNAPSES-1:0]   shadow_zero_q;
    logic [N_SYNAPSES-1:0]   shadow_sign_q;
    logic [N_SYNAPSES-1:0]   active_zero_q;
    logic [N_SYNAPSES-1:0]   active_sign_q;
    logic                    weights_valid_q;
    logic [1:0]              enc;

    // Returns {zero, sign} for one ternary code.
    function automatic logic [1:0] encode_weight(input logic signed [1:0] v);
        logic zero;
        logic sign;
        zero = (v == 2'sb00);
        sign = v[1] & ~zero;
`ifdef TERNARY_ILLEGAL_CHECK_EN
        // The illegal code is neutralised to a zero weight.
        if (v == 2'sb10) begin
            zero = 1'b1;
            sign = 1'b0;
        end
`endif
        return {zero, sign};
    endfunction

    assign enc       = encode_weight(bus.w_val);
    assign last_slot = (count_q == CNT_W'(N_SYNAPSES - 1));

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: if (accept && last_slot) state_d = ST_FULL;
                ST_FULL: if (bus.commit)          state_d = ST_LOAD;
                default:                          state_d = ST_LOAD;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs and control strobes
    // load_start outranks commit, which outranks accept. In FULL w_ready is
    // low, so a commit can never coincide with an accept there.
    // ------------------------------------------------------------------------
    always_comb begin
        w_ready_int = (state_q == ST_LOAD);
        restart     = bus.load_start;
        do_commit   = bus.commit && (state_q == ST_FULL) && !restart;
        accept      = bus.w_valid && w_ready_int && !restart;
    end

    // ------------------------------------------------------------------------
    // Fill counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (restart || do_commit) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Shadow bank: slot count_q receives the encoded weight on accept.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_zero_q <= '1;
            shadow_sign_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < N_SYNAPSES; i++) begin
                if (count_q == CNT_W'(i)) begin
                    shadow_zero_q[i] <= enc[1];
                    shadow_sign_q[i] <= enc[0];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Active bank: changes only on a commit accepted in FULL.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_zero_q   <= '1;
            active_sign_q   <= '0;
            weights_valid_q <= 1'b0;
        end else if (do_commit) begin
            active_zero_q   <= shadow_zero_q;
            active_sign_q   <= shadow_sign_q;
            weights_valid_q <= 1'b1;
        end
    end

`ifdef TERNARY_ILLEGAL_CHECK_EN
    logic err_q;

    // Sticky until reset; load_start and commit do not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && (bus.w_val == 2'sb10)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.w_ready       = w_ready_int;
    assign bus.count         = count_q;
    assign bus.weight_zero   = active_zero_q;
    assign bus.weight_sign   = active_sign_q;
    assign bus.weights_valid = weights_valid_q;

endmodule
